// File: rtl/decode.sv
// Hamming single-error-correcting decoder: syndrome -> single-bit flip -> data extraction,
// with registered data and valid. Layout: codeword bit i is Hamming position i+1.
module decode #(
  parameter int data_width     = 16,
  parameter int encoding_width = 21
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic [encoding_width-1:0] encoded_data,
  output logic [data_width-1:0]     decoded_data,
  output logic                      valid
);

  localparam int R = $clog2(encoding_width + 1);

  // Codeword bit index carrying data bit d: the d-th non-power-of-two position.
  function automatic int data_idx(input int d);
    int n;
    int idx;
    n   = 0;
    idx = 0;
    for (int p = 1; p <= encoding_width; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == d) idx = p - 1;
        n = n + 1;
      end
    end
    return idx;
  endfunction

  logic [R-1:0]              w_syn;
  logic [encoding_width-1:0] w_flip;
  logic [encoding_width-1:0] w_corr;
  logic [data_width-1:0]     w_data;
  logic                      w_ok;

  always_comb begin
    w_syn = '0;
    for (int i = 0; i < encoding_width; i++) begin
      for (int k = 0; k < R; k++) begin
        if (((i + 1) & (1 << k)) != 0) w_syn[k] = w_syn[k] ^ encoded_data[i];
      end
    end
  end

  // Syndromes beyond the codeword length match no position, so nothing is flipped
  // and the raw data passes through with valid low.
  always_comb begin
    w_flip = '0;
    for (int i = 0; i < encoding_width; i++) begin
      w_flip[i] = (w_syn == R'(i + 1));
    end
  end

  assign w_corr = encoded_data ^ w_flip;
  assign w_ok   = (w_syn <= R'(encoding_width));

  for (genvar d = 0; d < data_width; d++) begin : g_extract
    assign w_data[d] = w_corr[data_idx(d)];
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      decoded_data <= '0;
      valid        <= 1'b0;
    end else begin
      decoded_data <= w_data;
      valid        <= w_ok;
    end
  end

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for decode: stimulus pushes hand-computed expectations, a monitor
// pops and compares one cycle after each codeword is sampled.
module tb_decode;

  logic        clk = 1'b0;
  logic        rstb;
  logic [20:0] encoded_data;
  logic [15:0] decoded_data;
  logic        valid;

  typedef struct {
    logic [15:0] d;
    logic        v;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  decode #(.data_width(16), .encoding_width(21)) dut (
    .clk          (clk),
    .rstb         (rstb),
    .encoded_data (encoded_data),
    .decoded_data (decoded_data),
    .valid        (valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] got_d, input logic got_v,
                       input logic [15:0] exp_d, input logic exp_v);
    checks++;
    if (got_d !== exp_d || got_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got data=%0d valid=%b, expected data=%0d valid=%b",
               name, got_d, got_v, exp_d, exp_v);
    end
  endtask

  task automatic send(input string name, input logic [20:0] cw,
                      input logic [15:0] exp_d, input logic exp_v);
    exp_t e;
    @(negedge clk);
    encoded_data = cw;
    e.d = exp_d; e.v = exp_v; e.name = name;
    exp_q.push_back(e);
  endtask

  // Monitor: one result per sampled codeword, visible just after the sampling edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rstb && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.name, decoded_data, valid, e.d, e.v);
    end
  end

  initial begin
    rstb         = 1'b0;
    encoded_data = 21'd599040;
    #2;
    check("reset_async", decoded_data, valid, 16'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", decoded_data, valid, 16'd0, 1'b0);
    @(negedge clk);
    rstb = 1'b1;

    send("clean_82",          21'd82,       16'd10,    1'b1);
    send("clean_599040",      21'd599040,   16'd19008, 1'b1);
    send("err_bit7_parity8",  21'd599168,   16'd19008, 1'b1);
    send("err_bit6_data7",    21'd599104,   16'd19008, 1'b1);
    send("err_bit19_data20",  21'd74752,    16'd19008, 1'b1);
    send("err_bit0_parity1",  21'd599041,   16'd19008, 1'b1);
    send("err_bit20_pos21",   21'd1647616,  16'd19008, 1'b1);
    send("dbl_syn31",         21'd73728,    16'd2560,  1'b0);
    send("dbl_syn22",         21'd631840,   16'd19012, 1'b0);
    send("dbl_miscorrect",    21'd81,       16'd11,    1'b1);
    send("err_bit2_data3",    21'd86,       16'd10,    1'b1);
    send("zero",              21'd0,        16'd0,     1'b1);
    send("all_ones_data",     21'h1FFFFE,   16'hFFFF,  1'b1);
    send("all_ones_err_bit0", 21'h1FFFFF,   16'hFFFF,  1'b1);

    // Reset mid-stream: the codeword launched just before reset must be dropped.
    send("dropped_by_reset",  21'd82,       16'd10,    1'b1);
    #2;
    rstb = 1'b0;
    exp_q.delete();
    #1;
    check("reset_mid_async", decoded_data, valid, 16'd0, 1'b0);
    @(posedge clk);
    #2;
    check("reset_mid_held", decoded_data, valid, 16'd0, 1'b0);
    @(negedge clk);
    rstb = 1'b1;

    send("post_reset_599040", 21'd599040,   16'd19008, 1'b1);
    send("post_reset_dbl",    21'd73728,    16'd2560,  1'b0);
    send("post_reset_82",     21'd82,       16'd10,    1'b1);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
